// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_pkg
//  Description : Shared types and constants for the reorder buffer. Holds the
//                per-entry record and default sizing values.
//  Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

  // Default number of buffer entries
  localparam int c_ROB_SIZE   = 32;
  // Tag width: tag 0 means "value in register file", 1..c_ROB_SIZE name entries
  localparam int c_ROB_TAG_W  = $clog2(c_ROB_SIZE + 1);
  // Width of the stored result field
  localparam int c_ROB_DATA_W = 64;
  // Architectural register whose map-table entry is never cleared on retire
  localparam logic [4:0] c_NO_CLEAR_REG = 5'd31;

  // One reorder-buffer slot
  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic                    regWrite;
    logic [4:0]              destReg;
    logic [c_ROB_DATA_W-1:0] value;
  } robEntry_t;

endpackage
`default_nettype wire

// File: rtl/decoder5x32.sv
`default_nettype none
// ============================================================================
//  Module      : decoder5x32
//  Description : 5-to-32 one-hot decoder with enable; all outputs low when the
//                enable is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder5x32 (
  input  logic        en_i,
  input  logic [4:0]  sel_i,
  output logic [31:0] dec_o
);

  // Drive a single hot bit for the selected index while enabled
  always_comb begin
    dec_o = '0;
    if (en_i) begin
      dec_o[sel_i] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular reorder buffer. Allocates 1-based tags at decode,
//                captures CDB results, retires completed entries in program
//                order and emits the map-table clear vector on retire.
//                Optional feature macro: ROB_FLUSH_EN (adds flush_i, which
//                empties the buffer at the next clock edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROBsize      = c_ROB_SIZE,
  parameter int mapValueSize = $clog2(ROBsize + 1),
  parameter int dataWidth    = c_ROB_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef ROB_FLUSH_EN
  input  logic                    flush_i,
`endif
  input  logic                    alloc_valid_i,
  input  logic                    alloc_regWrite_i,
  input  logic [4:0]              alloc_destReg_i,
  output logic                    alloc_ready_o,
  output logic [mapValueSize-1:0] alloc_tag_o,
  input  logic                    complete_valid_i,
  input  logic [mapValueSize-1:0] complete_tag_i,
  input  logic [dataWidth-1:0]    complete_value_i,
  input  logic [mapValueSize-1:0] readTag1_i,
  input  logic [mapValueSize-1:0] readTag2_i,
  output logic [dataWidth-1:0]    readData1_o,
  output logic [dataWidth-1:0]    readData2_o,
  output logic                    readReady1_o,
  output logic                    readReady2_o,
  input  logic [mapValueSize-1:0] mapCommitTag_i,
  output logic [4:0]              commitReadAddr_o,
  output logic                    commit_valid_o,
  output logic                    commit_regWrite_o,
  output logic [4:0]              commit_destReg_o,
  output logic [dataWidth-1:0]    commit_value_o,
  output logic [31:0]             resets_o
);

  localparam int                      c_PTR_W = (ROBsize > 1) ? $clog2(ROBsize) : 1;
  localparam logic [c_PTR_W-1:0]      c_LAST  = c_PTR_W'(ROBsize - 1);
  localparam logic [mapValueSize-1:0] c_FULL  = mapValueSize'(ROBsize);
  localparam logic [mapValueSize-1:0] c_ONE   = mapValueSize'(1);

  robEntry_t                 r_rob [ROBsize];
  logic [c_PTR_W-1:0]        r_head;
  logic [c_PTR_W-1:0]        r_tail;
  logic [mapValueSize-1:0]   r_count;

  logic                      w_flush;
  logic                      w_alloc_fire;
  logic                      w_commit;
  logic                      w_cmp_hit;
  logic [c_PTR_W-1:0]        w_cmp_idx;
  logic [c_ROB_DATA_W-1:0]   w_cmp_value;
  logic [c_PTR_W-1:0]        w_head_next;
  logic [c_PTR_W-1:0]        w_tail_next;
  logic [mapValueSize-1:0]   w_head_tag;
  logic                      w_clear_en;
  robEntry_t                 w_head_e;
  robEntry_t                 w_rd1_e;
  robEntry_t                 w_rd2_e;
  logic                      w_rd1_hit;
  logic                      w_rd2_hit;

  // A tag names an entry only when it lies in 1..ROBsize
  function automatic logic tag_in_range(input logic [mapValueSize-1:0] tag);
    return (tag != '0) && (tag <= c_FULL);
  endfunction

  // Tags are 1-based; strip the offset to get the slot index
  function automatic logic [c_PTR_W-1:0] tag_to_idx(input logic [mapValueSize-1:0] tag);
    logic [mapValueSize-1:0] m1;
    m1 = tag - c_ONE;
    return m1[c_PTR_W-1:0];
  endfunction

`ifdef ROB_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  // Allocation looks only at registered occupancy, so a retire in the same
  // cycle does not open a slot in a full buffer until the next cycle.
  assign alloc_ready_o = (r_count != c_FULL);
  assign alloc_tag_o   = mapValueSize'(r_tail) + c_ONE;
  assign w_alloc_fire  = alloc_valid_i & alloc_ready_o;

  assign w_head_e    = r_rob[r_head];
  assign w_head_tag  = mapValueSize'(r_head) + c_ONE;
  assign w_head_next = (r_head == c_LAST) ? '0 : r_head + c_PTR_W'(1);
  assign w_tail_next = (r_tail == c_LAST) ? '0 : r_tail + c_PTR_W'(1);

  // Retire is decided purely from stored state; a same-cycle complete of the
  // head only becomes visible after the edge.
  assign w_commit = w_head_e.valid & w_head_e.done & ~w_flush;

  assign commit_valid_o    = w_commit;
  assign commit_regWrite_o = w_head_e.regWrite;
  assign commit_destReg_o  = w_head_e.destReg;
  assign commitReadAddr_o  = w_head_e.destReg;
  assign commit_value_o    = w_head_e.value[dataWidth-1:0];

  // Clear the map entry only if it still points at the retiring tag, so a
  // newer rename of the same register keeps its producer.
  assign w_clear_en = w_commit & w_head_e.regWrite &
                      (w_head_e.destReg != c_NO_CLEAR_REG) &
                      (mapCommitTag_i == w_head_tag);

  decoder5x32 u_clear_dec (
    .en_i  (w_clear_en),
    .sel_i (w_head_e.destReg),
    .dec_o (resets_o)
  );

  assign w_cmp_idx   = tag_to_idx(complete_tag_i);
  assign w_cmp_value = c_ROB_DATA_W'(complete_value_i);

  // Decode the CDB broadcast: act only on a tag naming a live entry
  always_comb begin
    w_cmp_hit = 1'b0;
    if (complete_valid_i && tag_in_range(complete_tag_i)) begin
      w_cmp_hit = r_rob[w_cmp_idx].valid;
    end
  end

  // Operand read ports; no forwarding from a same-cycle broadcast
  always_comb begin
    w_rd1_e      = r_rob[tag_to_idx(readTag1_i)];
    w_rd2_e      = r_rob[tag_to_idx(readTag2_i)];
    w_rd1_hit    = tag_in_range(readTag1_i) && w_rd1_e.valid;
    w_rd2_hit    = tag_in_range(readTag2_i) && w_rd2_e.valid;
    readReady1_o = w_rd1_hit && w_rd1_e.done;
    readReady2_o = w_rd2_hit && w_rd2_e.done;
    readData1_o  = w_rd1_hit ? w_rd1_e.value[dataWidth-1:0] : '0;
    readData2_o  = w_rd2_hit ? w_rd2_e.value[dataWidth-1:0] : '0;
  end

  // Entry storage, pointers and occupancy; flush overrides all other updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROBsize; i++) begin
        r_rob[i] <= '0;
      end
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROBsize; i++) begin
        r_rob[i] <= '0;
      end
    end else begin
      if (w_cmp_hit) begin
        r_rob[w_cmp_idx].done  <= 1'b1;
        r_rob[w_cmp_idx].value <= w_cmp_value;
      end
      if (w_alloc_fire) begin
        r_rob[r_tail].valid    <= 1'b1;
        r_rob[r_tail].done     <= 1'b0;
        r_rob[r_tail].regWrite <= alloc_regWrite_i;
        r_rob[r_tail].destReg  <= alloc_destReg_i;
        r_rob[r_tail].value    <= '0;
        r_tail                 <= w_tail_next;
      end
      if (w_commit) begin
        r_rob[r_head].valid <= 1'b0;
        r_head              <= w_head_next;
      end
      case ({w_alloc_fire, w_commit})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
